sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_padder.sv | 118 +++++++++++
 tb/tb_sha256_padder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into big-endian 512-bit blocks,
// appending 0x80, zero fill and the 64-bit message bit length.
//
// state  | meaning
// ACCEPT | collect message bytes into the block buffer at idx
// PAD    | place 0x80 and zero fill, plus length when it fits
// EMIT   | present block downstream; with blk_valid low, load the length-only block
module sha256_padder (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         blk_valid,
    output logic [511:0] blk_data,
    output logic         blk_last,
    input  logic         blk_ready,
    output logic [63:0]  msg_blocks
);

    typedef enum logic [1:0] {ACCEPT, PAD, EMIT} state_t;

    state_t      state;
    logic [5:0]  idx;
    logic [63:0] bit_len;
    logic [63:0] blk_cnt;
    logic        pad_pending;
    logic        len_pending;

    assign in_ready   = (state == ACCEPT) && !rst;
    // blk_cnt counts finished handshakes, so the presented block is one more
    assign msg_blocks = blk_valid ? blk_cnt + 64'd1 : blk_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACCEPT;
            idx         <= 6'd0;
            bit_len     <= 64'd0;
            blk_cnt     <= 64'd0;
            blk_data    <= 512'd0;
            blk_valid   <= 1'b0;
            blk_last    <= 1'b0;
            pad_pending <= 1'b0;
            len_pending <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (in_valid) begin
                        for (int i = 0; i < 64; i++) begin
                            if (idx == 6'(i)) blk_data[511-8*i -: 8] <= in_data;
                        end
                        bit_len <= bit_len + 64'd8;
                        idx     <= idx + 6'd1;
                        if (idx == 6'd63) begin
                            state       <= EMIT;
                            blk_valid   <= 1'b1;
                            blk_last    <= 1'b0;
                            pad_pending <= in_last;
                        end else if (in_last) begin
                            state <= PAD;
                        end
                    end
                end
                PAD: begin
                    for (int i = 0; i < 64; i++) begin
                        if (idx == 6'(i))
                            blk_data[511-8*i -: 8] <= 8'h80;
                        else if (6'(i) > idx)
                            blk_data[511-8*i -: 8] <= 8'h00;
                    end
                    if (idx <= 6'd55) begin
                        blk_data[63:0] <= bit_len;
                        blk_last       <= 1'b1;
                    end else begin
                        blk_last    <= 1'b0;
                        len_pending <= 1'b1;
                    end
                    blk_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (!blk_valid) begin
                        // only reached after a len_pending handshake
                        blk_data  <= {448'd0, bit_len};
                        blk_last  <= 1'b1;
                        blk_valid <= 1'b1;
                    end else if (blk_ready) begin
                        blk_cnt   <= blk_cnt + 64'd1;
                        blk_valid <= 1'b0;
                        if (blk_last) begin
                            state       <= ACCEPT;
                            idx         <= 6'd0;
                            bit_len     <= 64'd0;
                            blk_cnt     <= 64'd0;
                            blk_data    <= 512'd0;
                            blk_last    <= 1'b0;
                            pad_pending <= 1'b0;
                            len_pending <= 1'b0;
                        end else if (pad_pending) begin
                            state       <= PAD;
                            idx         <= 6'd0;
                            pad_pending <= 1'b0;
                        end else if (len_pending) begin
                            len_pending <= 1'b0;
                        end else begin
                            state    <= ACCEPT;
                            idx      <= 6'd0;
                            blk_data <= 512'd0;
                        end
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known padding vectors, latency,
// backpressure and reset-restart.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         blk_ready;
    logic [63:0]  msg_blocks;

    int n_checks = 0;
    int n_errors = 0;

    logic [511:0] q_data[$];
    logic         q_last[$];
    logic [63:0]  q_cnt[$];

    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 64'h18};

    sha256_padder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .blk_last   (blk_last),
        .blk_ready  (blk_ready),
        .msg_blocks (msg_blocks)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && blk_valid && blk_ready) begin
            q_data.push_back(blk_data);
            q_last.push_back(blk_last);
            q_cnt.push_back(msg_blocks);
        end
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 37 + 11) & 255);
    endfunction

    // block holding message bytes 0..n-1 (pattern), rest zero
    function automatic logic [511:0] data_blk(input int n);
        logic [511:0] b = '0;
        for (int i = 0; i < n; i++) b[511-8*i -: 8] = pat(i);
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l);
        int c = 0;
        @(negedge clk);
        while (!in_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (c >= 300) chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_pat(input int n, input logic final_last);
        for (int i = 0; i < n; i++) send_byte(pat(i), final_last && (i == n - 1));
    endtask

    task automatic send_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
    endtask

    task automatic wait_blocks(input int n);
        for (int c = 0; c < 300 && q_data.size() < n; c++) begin
            @(negedge clk);
            #1;
        end
        if (q_data.size() < n) chk("blk_wait", 512'(q_data.size()), 512'(n));
    endtask

    task automatic chk_blk(input string tag, input logic [511:0] d, input logic l, input logic [63:0] cnt);
        if (q_data.size() == 0) begin
            chk({tag, "_missing"}, 0, 1);
        end else begin
            chk({tag, "_data"}, q_data.pop_front(), d);
            chk({tag, "_last"}, q_last.pop_front(), l);
            chk({tag, "_cnt"}, q_cnt.pop_front(), cnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        blk_ready = 1'b1;
        #13;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_last", blk_last, 0);
        chk("rst_blk_data", blk_data, 0);
        chk("rst_msg_blocks", msg_blocks, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // "abc" with latency check: PAD cycle, then block
        send_abc();
        chk("abc_lat_n1", blk_valid, 0);
        @(posedge clk);
        #1;
        chk("abc_lat_n2", blk_valid, 1);
        wait_blocks(1);
        chk_blk("abc", ABC_BLK, 1'b1, 64'd1);
        @(posedge clk);
        #1;
        chk("abc_in_ready_after", in_ready, 1);

        // 55 bytes: 0x80 and length fit in one block
        send_pat(55, 1'b1);
        wait_blocks(1);
        chk_blk("m55", data_blk(55) | {440'd0, 8'h80, 64'h1B8}, 1'b1, 64'd1);

        // 56 bytes: length spills into a second block
        send_pat(56, 1'b1);
        wait_blocks(2);
        chk_blk("m56_b1", data_blk(56) | {448'd0, 8'h80, 56'd0}, 1'b0, 64'd1);
        chk_blk("m56_b2", {448'd0, 64'h1C0}, 1'b1, 64'd2);

        // 64 bytes under backpressure
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        send_pat(64, 1'b1);
        chk("m64_lat", blk_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", blk_valid, 1);
            chk("bp_data", blk_data, data_blk(64));
            chk("bp_in_ready", in_ready, 0);
        end
        chk("bp_no_xfer", 512'(q_data.size()), 0);
        blk_ready = 1'b1;
        wait_blocks(1);
        @(posedge clk);
        #1;
        chk("m64_single_xfer", blk_valid, 0);
        wait_blocks(2);
        chk_blk("m64_b1", data_blk(64), 1'b0, 64'd1);
        chk_blk("m64_b2", {8'h80, 440'd0, 64'h200}, 1'b1, 64'd2);
        @(posedge clk);
        #1;
        chk("m64_in_ready_after", in_ready, 1);

        // reset partway through a message, then restart
        send_pat(30, 1'b0);
        rst = 1'b1;
        #2;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_blk_data", blk_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_blk", 512'(q_data.size()), 0);
        send_abc();
        wait_blocks(1);
        chk_blk("abc2", ABC_BLK, 1'b1, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
